// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and sizing helpers for the multiply/divide unit
//
// Purpose: op codes, FSM state encodings, and the iteration-counter width
// function used by mdu and mdu_step.
// Ports: none (package).
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

  // Iteration counter must hold 0..WIDTH-1 with headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational shift-add / restoring-divide iteration
//
// Purpose: advances the shared accumulator by one multiplier bit (mult) or
// one quotient bit (div).
// Ports:
//   acc      in  2*WIDTH+1  current accumulator
//   opnd     in  WIDTH      multiplicand (mult) or divisor (div), as magnitude
//   div_mode in  1          1 = divide iteration, 0 = multiply iteration
//   acc_nxt  out 2*WIDTH+1  accumulator after this iteration
//
// Mult layout: acc[2W-1:W] partial product high half, acc[W-1:0] holds the
//   remaining multiplier bits and collects the low product bits.
// Div layout:  acc[2W:W] partial remainder (W+1 bits), acc[W-1:0] holds the
//   remaining dividend bits and collects quotient bits.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic             div_mode,
  output logic [2*WIDTH:0] acc_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shifted = {acc[2*WIDTH:WIDTH], acc[WIDTH-1]};
    trial   = shifted - {2'b00, opnd};
    acc_nxt = acc;
    if (div_mode) begin
      // Restore (keep the shifted remainder) when the trial subtract borrows.
      if (!trial[WIDTH+1]) begin
        acc_nxt = {trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {shifted[WIDTH:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      // The carry out of the add becomes the new top bit after the shift.
      acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
    end else begin
      acc_nxt = {2'b00, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative multiply/divide unit with architectural HI/LO
//
// Purpose: signed/unsigned 32x32->64 multiply and 32/32 divide, one bit per
// cycle, results written to HI/LO; mthi/mtlo writes while idle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, op, a, b   launch request, operation, operands (sampled in IDLE)
//   cancel            abort an in-flight operation
//   hi_we, lo_we      mthi/mtlo enables, wdata their data
//   busy              operation in flight
//   done              one-cycle pulse when HI/LO take a result
//   hi, lo            HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam int AW = 2 * WIDTH + 1;

  mdu_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc, acc_step;
  logic [WIDTH-1:0] opnd;
  logic             is_div, neg_q, neg_r, dz;

  logic             op_div, op_signed, sa, sb, b_zero, last_iter;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] quo, rem;
  logic [2*WIDTH-1:0] prod;

  assign op_div    = op[1];
  assign op_signed = ~op[0];
  assign sa        = op_signed & a[WIDTH-1];
  assign sb        = op_signed & b[WIDTH-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag_a     = sa ? (~a + 1'b1) : a;
  assign mag_b     = sb ? (~b + 1'b1) : b;
  assign b_zero    = (b == '0);
  assign last_iter = (cnt == CW'(WIDTH - 1));

  assign quo  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  assign prod = neg_q ? (~acc[2*WIDTH-1:0] + 1'b1) : acc[2*WIDTH-1:0];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .div_mode (is_div),
    .acc_nxt  (acc_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (op_div && b_zero) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_nxt = S_IDLE;
        end else if (last_iter) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            cnt    <= '0;
            is_div <= op_div;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= op_div & b_zero;
            opnd   <= op_div ? mag_b : mag_a;
            // Divide by zero keeps the raw dividend so HI can return it.
            if (op_div && b_zero) begin
              acc <= {{(WIDTH + 1){1'b0}}, a};
            end else begin
              acc <= {{(WIDTH + 1){1'b0}}, op_div ? mag_a : mag_b};
            end
          end
        end
        S_CALC: begin
          if (!cancel) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!cancel) begin
            done <= 1'b1;
            if (dz) begin
              hi <= acc[WIDTH-1:0];
              lo <= '1;
            end else if (is_div) begin
              hi <= rem;
              lo <= quo;
            end else begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed table-driven bench for mdu
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          elat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns edges from the start edge until done is seen (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        output int lat);
    start = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("done_low_after_start", {63'd0, done}, 64'd0);
    while (!done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) lat = -1;
    check("busy_low_with_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat;
    logic saw_done;
    logic [31:0] prev_hi, prev_lo;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[4]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1};
    vecs[5]  = '{2'b10, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};
    vecs[9]  = '{2'b00, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 33};
    vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33};
    vecs[11] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table, issued back-to-back (each start lands while done is high)
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].elat));
      check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].ehi});
      check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].elo});
    end
    @(negedge clk);
    check("done_single_pulse", {63'd0, done}, 64'd0);

    // Cancel at E10: no result, HI/LO keep the previous values
    prev_hi = hi; prev_lo = lo;
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy_low", {63'd0, busy}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("cancel_no_done", {63'd0, saw_done}, 64'd0);
    check("cancel_hi_kept", {32'd0, hi}, {32'd0, prev_hi});
    check("cancel_lo_kept", {32'd0, lo}, {32'd0, prev_lo});

    // mthi in IDLE
    hi_we = 1'b1; wdata = 32'h000000AA;
    @(posedge clk);
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle_hi", {32'd0, hi}, 64'h00000000_000000AA);
    check("mthi_idle_lo", {32'd0, lo}, {32'd0, prev_lo});

    // mtlo while busy and a second start while busy are both ignored
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      lo_we = (lat == 3);
      wdata = 32'h00000055;
      start = (lat == 6);
      if (lat == 6) begin
        op = 2'b11; a = 32'd1; b = 32'd0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    lo_we = 1'b0; start = 1'b0;
    if (!done) lat = -1;
    check("busy_writes_latency", 64'(lat), 64'd33);
    check("busy_writes_hi", {32'd0, hi}, 64'd0);
    check("busy_writes_lo", {32'd0, lo}, 64'd30);

    // mthi on the same edge as start: the result overwrites it
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h00000077;
    run_op(2'b00, 32'd2, 32'd3, lat);
    check("mthi_start_latency", 64'(lat), 64'd33);
    check("mthi_start_hi", {32'd0, hi}, 64'd0);
    check("mthi_start_lo", {32'd0, lo}, 64'd6);

    // Reset mid-operation discards everything
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_done", {63'd0, done}, 64'd0);
    check("midreset_hi", {32'd0, hi}, 64'd0);
    check("midreset_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b01, 32'd3, 32'd4, lat);
    check("after_reset_latency", 64'(lat), 64'd33);
    check("after_reset_hi", {32'd0, hi}, 64'd0);
    check("after_reset_lo", {32'd0, lo}, 64'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit in the EX stage, beside the add/sub ALU. Takes the same two operand buses, computes signed/unsigned 32×32→64 products or 32/32 quotient/remainder over multiple cycles, and holds results in architectural HI/LO registers. The writeback path reads HI/LO for mfhi/mflo. The hazard unit stalls the pipeline on `busy`.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: launch operation; sampled only in IDLE.
- `op` in 2: 00 mult, 01 multu, 10 div, 11 divu; sampled with `start`.
- `a`, `b` in WIDTH: operands (dividend/divisor for div); sampled with `start`.
- `cancel` in 1: abort an in-flight operation (pipeline flush).
- `hi_we`, `lo_we` in 1: mthi/mtlo write enables.
- `wdata` in WIDTH: mthi/mtlo data.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when HI/LO receive a result.
- `hi`, `lo` out WIDTH: architectural HI/LO registers.

## Operation
- FSM states:
  - IDLE -> CALC on `start`.
  - IDLE -> FIX on `start` with div/divu and `b`==0.
  - CALC -> FIX after WIDTH iterations.
  - FIX -> IDLE, writing HI/LO and pulsing `done`.
- Signed ops store operand magnitudes plus sign flags at start. Unsigned ops use operands as-is.
- Mult: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per CALC cycle. In FIX, negate the 64-bit product if sign(a)≠sign(b). HI = upper half, LO = lower half.
- Div: restoring division, one quotient bit per CALC cycle, WIDTH+1-bit partial remainder. In FIX:
  - quotient sign = sign(a)^sign(b);
  - remainder sign = sign(a);
  - LO = quotient, HI = remainder.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000 (two's-complement wrap), HI = 0.
- Divide by zero, signed or unsigned: no CALC. FIX writes HI = a, LO = all ones.
- `start` while `busy`: ignored, no effect.
- `cancel` in CALC or FIX: next state IDLE, HI/LO unchanged, no `done`. `cancel` in IDLE: no effect.
- `hi_we`/`lo_we`: honoured only in IDLE; ignored while `busy`.
  - In IDLE with `start` on the same edge, the write lands at that edge. The later result overwrites it.
- Reset: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, internal accumulators cleared. Reset mid-operation discards the operation.

## Timing
- Start edge E0, `start`=1 in IDLE:
  - `busy`=1 from E0 until E(WIDTH+1);
  - iterations at E1..E(WIDTH);
  - FIX at E(WIDTH+1) writes HI/LO;
  - `done`=1 and `busy`=0 for the cycle after E(WIDTH+1).
- Latency: 33 edges for WIDTH=32. Divide by zero: FIX at E1, `done` after E1.
- Back-to-back: a new `start` is accepted on the edge after FIX, i.e. while `done` is high.
- `busy`, `done`, `hi`, `lo` are all registered. No combinational path from inputs to outputs.

## Structure
- Package `mdu_pkg`:
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - state encodings `S_IDLE`, `S_CALC`, `S_FIX`;
  - iteration-counter width `$clog2(WIDTH)+1`.
- One sub-module, `mdu_step`: combinational single iteration for both mult and div. Inputs: accumulator, operand, mode. Outputs: next accumulator. The top holds the FSM, counter, sign flags, and HI/LO.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 edges `done`, HI=0xFFFFFFFE, LO=0x00000001.
- mult a=0xFFFFFFFD (−3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21).
- div a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu a=0x1234, b=0 -> `done` after E1, HI=0x1234, LO=0xFFFFFFFF.
- multu 5×6 with `cancel` at E10 -> `busy`=0 after E10, no `done`, HI/LO keep prior values.
- mthi wdata=0xAA in IDLE -> HI=0xAA. mtlo during `busy` -> LO unchanged. Second `start` during `busy` -> ignored, first result intact.
